frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/frame_pkg.sv | 22 ++
 rtl/stream_fifo2.sv | 54 +++++
 rtl/frame_streamer.sv | 133 +++++++++++++
 tb/tb_frame_streamer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared constants, pixel type and state encoding for frame_streamer
package frame_pkg;

  localparam int DEF_IMG_WIDTH  = 650;
  localparam int DEF_IMG_HEIGHT = 480;
  localparam int DEF_PIX_W      = 8;

  function automatic int addr_width(input int w, input int h);
    return $clog2(w * h);
  endfunction

  localparam int DEF_ADDR_W = addr_width(DEF_IMG_WIDTH, DEF_IMG_HEIGHT);

  typedef logic [DEF_PIX_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// rtl/stream_fifo2.sv - two-entry valid/ready buffer with synchronous flush
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic [W-1:0] in_tdata,
  input  logic         in_tvalid,
  output logic         in_tready,
  output logic [W-1:0] out_tdata,
  output logic         out_tvalid,
  input  logic         out_tready,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         push;
  logic         pop;

  assign in_tready  = (count != 2'd2);
  assign out_tvalid = (count != 2'd0);
  assign out_tdata  = mem[rd_ptr];
  assign push       = in_tvalid && in_tready;
  assign pop        = out_tvalid && out_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_tdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_streamer.sv
// rtl/frame_streamer.sv - streams one frame from a frame buffer in raster order with sof/eol/eof markers
module frame_streamer
  import frame_pkg::*;
#(
  parameter int  IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int  IMG_HEIGHT = DEF_IMG_HEIGHT,
  parameter int  W          = DEF_PIX_W,
  localparam int ADDR_W     = addr_width(IMG_WIDTH, IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [W-1:0]      mem_rd_data,
  output logic              y_valid,
  input  logic              y_ready,
  output logic [W-1:0]      y_data,
  output logic              y_sof,
  output logic              y_eol,
  output logic              y_eof
);

  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_pending;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        fifo_count;
  logic              unused_in_ready;
  logic              flush;
  logic              y_fire;
  logic              last_pix;
  logic [2:0]        committed;
  logic              room;

  assign busy      = (state != ST_IDLE);
  assign flush     = abort && busy;
  assign y_fire    = y_valid && y_ready;
  assign last_pix  = (col == LAST_COL) && (row == LAST_ROW);
  // Slots already spoken for: buffered entries plus a read whose data lands next edge.
  assign committed = 3'(fifo_count) + 3'(rd_pending);
  assign room      = committed < (3'd2 + 3'(y_fire));
  assign mem_addr  = rd_addr;
  assign y_sof     = y_valid && (col == '0) && (row == '0);
  assign y_eol     = y_valid && (col == LAST_COL);
  assign y_eof     = y_valid && last_pix;

  stream_fifo2 #(.W(W)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_tdata   (mem_rd_data),
    .in_tvalid  (rd_pending),
    .in_tready  (unused_in_ready),
    .out_tdata  (y_data),
    .out_tvalid (y_valid),
    .out_tready (y_ready),
    .count      (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    mem_rd_en = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !abort) state_nx = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (room) begin
          mem_rd_en = 1'b1;
          if (rd_addr == LAST_ADDR) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (y_fire && last_pix) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_addr    <= '0;
      rd_pending <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else if (flush) begin
      rd_addr    <= '0;
      rd_pending <= 1'b0;
      col        <= '0;
      row        <= '0;
    end else begin
      rd_pending <= mem_rd_en;
      if (mem_rd_en) rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + ADDR_W'(1);
      if (y_fire) begin
        if (done) begin
          col <= '0;
          row <= '0;
        end else if (col == LAST_COL) begin
          col <= '0;
          if (row != LAST_ROW) row <= row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// tb/tb_frame_streamer.sv - randomized self-checking bench for frame_streamer against a raster-order model
module tb_frame_streamer;

  localparam int IW   = 4;
  localparam int IH   = 3;
  localparam int NPIX = IW * IH;
  localparam int AW   = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, abort, y_ready;
  logic          busy, done, mem_rd_en, y_valid, y_sof, y_eol, y_eof;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rd_data, y_data;

  int checks = 0;
  int failures = 0;

  logic [10:0] got_q[$];
  int          done_cnt, done_idx, done_cyc, stall_viol, timed_out;

  frame_streamer #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .y_sof(y_sof), .y_eol(y_eol), .y_eof(y_eof)
  );

  always #5 clk = ~clk;

  // Frame buffer: contents are address + 0x10, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'(mem_addr) + 8'h10;
  end

  function automatic logic [10:0] exp_word(input int k);
    logic s, l, f;
    s = (k == 0);
    l = ((k % IW) == IW - 1);
    f = (k == NPIX - 1);
    return {s, l, f, 8'(k + 16)};
  endfunction

  function automatic int frame_errs(output int bad_idx);
    int n = 0;
    bad_idx = -1;
    for (int k = 0; k < got_q.size(); k++) begin
      if (k >= NPIX || got_q[k] !== exp_word(k)) begin
        n++;
        if (bad_idx < 0) bad_idx = k;
      end
    end
    return n;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes transfers until done, stop_after transfers, or a cycle budget; caller is at a negedge.
  task automatic collect(input int mode, input int stop_after);
    int          cyc = 0;
    logic        prev_stall = 1'b0;
    logic [11:0] prev_vec = '0;
    got_q.delete();
    done_cnt = 0; done_idx = -1; done_cyc = -1; stall_viol = 0; timed_out = 0;
    while (1) begin
      case (mode)
        0:       y_ready = 1'b1;
        1:       y_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: y_ready = 1'($urandom_range(0, 1));
      endcase
      if (mode == 3) start = ($urandom_range(0, 3) == 0);
      #1;
      if (prev_stall && {y_valid, y_data, y_sof, y_eol, y_eof} !== prev_vec) stall_viol++;
      prev_stall = y_valid && !y_ready;
      prev_vec   = {y_valid, y_data, y_sof, y_eol, y_eof};
      if (y_valid && y_ready) got_q.push_back({y_sof, y_eol, y_eof, y_data});
      if (done) begin
        done_cnt++;
        done_idx = got_q.size();
        done_cyc = cyc;
      end
      cyc++;
      @(negedge clk);
      if (done_cnt > 0 || (stop_after > 0 && got_q.size() >= stop_after)) break;
      if (cyc >= 400) begin
        timed_out = 1;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; y_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol, y_eof} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol, y_eof});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b rd_en=%b want 0 0", busy, mem_rd_en);
    end
  endtask

  task automatic test_full_frame();
    int bad, idx;
    y_ready = 1'b1;
    pulse_start();
    #1;
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_edge1 y_valid=%b busy=%b want 0 1", y_valid, busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL latency_edge2 y_valid=%b want 0", y_valid);
    end
    @(negedge clk);
    #1;
    checks++;
    if (y_valid !== 1'b1) begin
      failures++;
      $display("FAIL latency_edge3 y_valid=%b want 1", y_valid);
    end
    collect(0, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0) begin
      failures++;
      $display("FAIL full_frame_data count=%0d bad=%0d first_bad=%0d want count=%0d bad=0", got_q.size(), bad, idx, NPIX);
    end
    checks++;
    if (done_cyc !== NPIX - 1) begin
      failures++;
      $display("FAIL full_frame_no_bubbles done_cycle=%0d want %0d", done_cyc, NPIX - 1);
    end
    checks++;
    if (done_cnt !== 1 || done_idx !== NPIX) begin
      failures++;
      $display("FAIL full_frame_done count=%0d at_pixel=%0d want 1 at %0d", done_cnt, done_idx, NPIX);
    end
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_frame_end busy=%b done=%b y_valid=%b want 0 0 0", busy, done, y_valid);
    end
  endtask

  task automatic test_backpressure();
    int bad, idx;
    pulse_start();
    collect(1, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0 || timed_out !== 0) begin
      failures++;
      $display("FAIL backpressure_data count=%0d bad=%0d first_bad=%0d timeout=%0d want %0d 0", got_q.size(), bad, idx, timed_out, NPIX);
    end
    checks++;
    if (stall_viol !== 0) begin
      failures++;
      $display("FAIL backpressure_stable violations=%0d want 0", stall_viol);
    end
    checks++;
    if (done_cnt !== 1 || done_idx !== NPIX) begin
      failures++;
      $display("FAIL backpressure_done count=%0d at_pixel=%0d want 1 at %0d", done_cnt, done_idx, NPIX);
    end
  endtask

  task automatic test_stall20();
    int rd_cnt = 0, vcnt = 0, held_bad = 0, bad, idx;
    y_ready = 1'b0;
    pulse_start();
    for (int c = 0; c < 22; c++) begin
      #1;
      if (mem_rd_en) rd_cnt++;
      if (y_valid) begin
        vcnt++;
        if (y_data !== 8'h10) held_bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (rd_cnt > 2) begin
      failures++;
      $display("FAIL stall_reads issued=%0d want <=2", rd_cnt);
    end
    checks++;
    if (vcnt !== 20 || held_bad !== 0) begin
      failures++;
      $display("FAIL stall_hold valid_cycles=%0d wrong_data=%0d want 20 0", vcnt, held_bad);
    end
    collect(0, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0) begin
      failures++;
      $display("FAIL stall_resume count=%0d bad=%0d first_bad=%0d want %0d 0", got_q.size(), bad, idx, NPIX);
    end
  endtask

  task automatic test_abort();
    int bad, idx;
    pulse_start();
    collect(0, 5);
    abort = 1'b1;
    y_ready = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0 || done_cnt !== 0 || got_q.size() !== 5) begin
      failures++;
      $display("FAIL abort_no_done done=%b done_cnt=%0d pixels=%0d want 0 0 5", done, done_cnt, got_q.size());
    end
    @(negedge clk);
    abort = 1'b0;
    #1;
    checks++;
    if (y_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle y_valid=%b busy=%b done=%b want 0 0 0", y_valid, busy, done);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (y_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet y_valid=%b rd_en=%b want 0 0", y_valid, mem_rd_en);
    end
    @(negedge clk);
    pulse_start();
    collect(2, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL abort_restart count=%0d bad=%0d first_bad=%0d done=%0d want %0d 0 1", got_q.size(), bad, idx, done_cnt, NPIX);
    end
  endtask

  task automatic test_reset_mid();
    int rd_cnt = 0, bad, idx;
    pulse_start();
    collect(0, 7);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol, y_eof} !== 19'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%h want=0", {busy, done, mem_rd_en, mem_addr, y_valid, y_data, y_sof, y_eol, y_eof});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      if (mem_rd_en || y_valid || busy) rd_cnt++;
    end
    checks++;
    if (rd_cnt !== 0) begin
      failures++;
      $display("FAIL reset_mid_waits active_cycles=%0d want 0", rd_cnt);
    end
    @(negedge clk);
    pulse_start();
    collect(0, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0 || done_cnt !== 1) begin
      failures++;
      $display("FAIL reset_mid_restart count=%0d bad=%0d first_bad=%0d done=%0d want %0d 0 1", got_q.size(), bad, idx, done_cnt, NPIX);
    end
  endtask

  task automatic test_start_ignored();
    int bad, idx;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL start_with_abort busy=%b rd_en=%b want 0 0", busy, mem_rd_en);
    end
    @(negedge clk);
    pulse_start();
    collect(3, 0);
    bad = frame_errs(idx);
    checks++;
    if (got_q.size() !== NPIX || bad !== 0 || done_cnt !== 1 || stall_viol !== 0) begin
      failures++;
      $display("FAIL start_during_frame count=%0d bad=%0d first_bad=%0d done=%0d stall=%0d want %0d 0 1 0", got_q.size(), bad, idx, done_cnt, stall_viol, NPIX);
    end
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_during_frame_end busy=%b want 0", busy);
    end
  endtask

  task automatic test_back_to_back();
    int bad, idx;
    for (int f = 0; f < 3; f++) begin
      pulse_start();
      collect(2, 0);
      bad = frame_errs(idx);
      checks++;
      if (got_q.size() !== NPIX || bad !== 0 || done_cnt !== 1 || stall_viol !== 0 || timed_out !== 0) begin
        failures++;
        $display("FAIL back_to_back_%0d count=%0d bad=%0d first_bad=%0d done=%0d stall=%0d want %0d 0 1 0", f, got_q.size(), bad, idx, done_cnt, stall_viol, NPIX);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_stall20();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
